sobel_wr_arbiter: RTL and testbench
===================================

// Module: sobel_wr_arbiter
// PURPOSE
//  Shares one 64-bit frame-memory write port between two sobel output streams
//  (two concurrent pixel pipelines). Each stream's strobed writes are buffered
//  in a private FIFO and drained round-robin, one word per cycle, under memory
//  backpressure. Issued words are counted per frame; a frame_done pulse marks
//  the last word. Sits between the sobel output blocks and the frame RAM.
// PARAMETERS
//  DATA_W           64     write data width
//  ADDR_W           20     write address width
//  FIFO_DEPTH       4      words per requester FIFO; power of 2, >=2
//  WORDS_PER_FRAME  65536  words issued per frame; frame_done on the last one
// PORTS
//  clk         in   1       clock
//  reset       in   1       synchronous, active-high
//  req0_we     in   1       requester 0 write strobe, 1 word per high cycle
//  req0_addr   in   ADDR_W  requester 0 write address
//  req0_data   in   DATA_W  requester 0 write data
//  req1_we     in   1       requester 1 write strobe
//  req1_addr   in   ADDR_W  requester 1 write address
//  req1_data   in   DATA_W  requester 1 write data
//  mem_ready   in   1       memory can take a word next cycle
//  mem_we      out  1       memory write strobe, registered
//  mem_addr    out  ADDR_W  memory write address, registered
//  mem_data    out  DATA_W  memory write data, registered
//  frame_done  out  1       1-cycle pulse, coincident with last word of frame
//  ovf0        out  1       sticky: requester 0 word dropped (FIFO full)
//  ovf1        out  1       sticky: requester 1 word dropped (FIFO full)
//  busy        out  1       any FIFO non-empty or mem_we high
// BEHAVIOUR
//  - Reset: FIFOs empty, mem_we/mem_addr/mem_data/frame_done/ovf0/ovf1 = 0,
//    word_cnt = 0, rr pointer = req0 preferred. Reset overrides all activity;
//    in-flight and buffered words are discarded. Push and pop are both
//    ignored in the reset cycle.
//  - Push: reqN_we=1 at edge writes {addr,data} into FIFO N.
//    - FIFO full with no pop in the same cycle: the word is dropped and ovfN
//      is set; ovfN is cleared only by reset.
//    - FIFO full with a pop in the same cycle: the push is accepted (no
//      overflow).
//  - Arbitration, combinational each cycle:
//    - Eligible when mem_ready=1 and at least one FIFO is non-empty.
//    - Both non-empty: grant the requester not granted last (round-robin).
//      One non-empty: grant it.
//    - The rr pointer updates only on a grant.
//  - Issue: on a grant, pop the head; at the next edge mem_we=1 and
//    mem_addr/mem_data = popped word. Otherwise mem_we=0 and mem_addr/mem_data
//    hold their last values.
//  - Latency: a word pushed into an empty FIFO at edge N appears on the mem
//    port after edge N+1, provided mem_ready=1 and it wins arbitration.
//  - Throughput: max 1 word/cycle total. No word is reordered within a
//    requester. No word is duplicated.
//  - Frame count: word_cnt increments on each issued word.
//    - When the issued word is number WORDS_PER_FRAME-1, frame_done=1 in the
//      same cycle as its mem_we and word_cnt wraps to 0.
//    - word_cnt width is clog2(WORDS_PER_FRAME).
//  - mem_ready low: no pops. FIFOs keep filling and can overflow as above.
//  - busy = |fifo_count0 | |fifo_count1 | mem_we.
//  - Address/data pass through unmodified; no range checking.
// TESTING
//  1. Reset, single req0 write addr=0x00010 data=0xA5 with mem_ready=1 ->
//     mem_we=1 one cycle, addr 0x00010, data 0xA5, exactly 1 cycle after push.
//  2. req0 and req1 strobed every cycle, 8 words each, mem_ready=1 ->
//     mem port alternates 0,1,0,1...; all 16 words in per-requester order;
//     ovf0=ovf1=0 at FIFO_DEPTH=4 only if drain keeps up, else check the
//     first dropped index.
//  3. mem_ready=0, 5 req0 writes -> first 4 buffered, 5th dropped, ovf0=1
//     sticky. Then mem_ready=1 -> exactly 4 words out in order, busy falls
//     after the last one.
//  4. FIFO full and mem_ready=1, push and pop same cycle -> push accepted,
//     ovf0 stays 0, count unchanged.
//  5. WORDS_PER_FRAME=8, 9 writes -> frame_done pulses with the 8th mem_we
//     only; the 9th word is counted as word 0 of the next frame.
//  6. Assert reset with 3 words buffered and mem_we high -> next cycle
//     mem_we=0, busy=0, ovf cleared; no buffered word is ever issued.

Source files
------------

// File: rtl/sobel_wr_if.sv
// Bundles the two sobel write streams and the shared frame-memory write port.
// master drives the requests and mem_ready; slave is the arbiter side.
interface sobel_wr_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 20
);
  logic              req0_we;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req1_we;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              mem_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              frame_done;
  logic              ovf0;
  logic              ovf1;
  logic              busy;

  modport master (
    output req0_we, req0_addr, req0_data, req1_we, req1_addr, req1_data, mem_ready,
    input  mem_we, mem_addr, mem_data, frame_done, ovf0, ovf1, busy
  );

  modport slave (
    input  req0_we, req0_addr, req0_data, req1_we, req1_addr, req1_data, mem_ready,
    output mem_we, mem_addr, mem_data, frame_done, ovf0, ovf1, busy
  );
endinterface

// File: rtl/sobel_wr_arbiter.sv
// Two-requester write arbiter: per-stream FIFOs drained round-robin into one
// registered memory write port, with per-frame word counting.
module sobel_wr_arbiter #(
  parameter int DATA_W          = 64,
  parameter int ADDR_W          = 20,
  parameter int FIFO_DEPTH      = 4,
  parameter int WORDS_PER_FRAME = 65536
) (
  input logic      clk,
  input logic      reset,
  sobel_wr_if.slave bus
);
  localparam int WORD_W = ADDR_W + DATA_W;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int FRM_W  = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;

  logic [WORD_W-1:0] fifo_mem [2][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr [2];
  logic [PTR_W-1:0]  rd_ptr [2];
  logic [CNT_W-1:0]  count [2];
  logic [WORD_W-1:0] push_word [2];
  logic [1:0]        push;
  logic [1:0]        pop;
  logic [1:0]        accept;
  logic [1:0]        non_empty;
  logic [1:0]        ovf;
  logic              grant_valid;
  logic              grant_sel;
  logic              last_grant;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_data_q;
  logic              frame_done_q;
  logic [FRM_W-1:0]  word_cnt;

  // A full FIFO still accepts a push when its head leaves in the same cycle.
  always_comb begin
    push         = {bus.req1_we, bus.req0_we};
    push_word[0] = {bus.req0_addr, bus.req0_data};
    push_word[1] = {bus.req1_addr, bus.req1_data};
    for (int i = 0; i < 2; i++) begin
      non_empty[i] = (count[i] != '0);
    end
    grant_valid = bus.mem_ready && (non_empty != 2'b00);
    grant_sel   = (non_empty == 2'b11) ? ~last_grant : non_empty[1];
    pop         = 2'b00;
    if (grant_valid) begin
      pop[grant_sel] = 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      accept[i] = push[i] && ((count[i] != CNT_W'(FIFO_DEPTH)) || pop[i]);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset && accept[i]) begin
        fifo_mem[i][wr_ptr[i]] <= push_word[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
        ovf[i]    <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (accept[i]) begin
          wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        end
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        end
        if (accept[i] && !pop[i]) begin
          count[i] <= count[i] + CNT_W'(1);
        end else if (!accept[i] && pop[i]) begin
          count[i] <= count[i] - CNT_W'(1);
        end
        if (push[i] && !accept[i]) begin
          ovf[i] <= 1'b1;
        end
      end
    end
  end

  // Address/data hold their last issued value while no word is granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      frame_done_q <= 1'b0;
      word_cnt     <= '0;
      last_grant   <= 1'b1;
    end else begin
      mem_we_q     <= grant_valid;
      frame_done_q <= 1'b0;
      if (grant_valid) begin
        {mem_addr_q, mem_data_q} <= fifo_mem[grant_sel][rd_ptr[grant_sel]];
        last_grant               <= grant_sel;
        if (word_cnt == FRM_W'(WORDS_PER_FRAME - 1)) begin
          word_cnt     <= '0;
          frame_done_q <= 1'b1;
        end else begin
          word_cnt <= word_cnt + FRM_W'(1);
        end
      end
    end
  end

  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_data   = mem_data_q;
  assign bus.frame_done = frame_done_q;
  assign bus.ovf0       = ovf[0];
  assign bus.ovf1       = ovf[1];
  assign bus.busy       = non_empty[0] | non_empty[1] | mem_we_q;
endmodule

// File: tb/tb_sobel_wr_arbiter.sv
// Scoreboard bench for sobel_wr_arbiter; requester 1 words carry address bit 19
// so the monitor can route each issued word back to its expected queue.
module tb_sobel_wr_arbiter;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 20;
  localparam int DEPTH  = 4;
  localparam int WPF    = 8;

  typedef logic [ADDR_W+DATA_W-1:0] word_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sobel_wr_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  sobel_wr_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .WORDS_PER_FRAME(WPF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  word_t q0[$];
  word_t q1[$];
  bit    id_log[$];
  int    total   = 0;
  int    bad     = 0;
  int    issued  = 0;
  bit    mon_en  = 1'b0;

  // Monitor: every issued word must match its requester's queue head and
  // frame_done must accompany exactly every WPF-th word since reset.
  always @(negedge clk) begin : monitor
    word_t got;
    word_t exp;
    bit    id;
    if (mon_en && !reset) begin
      if (bus.mem_we === 1'b1) begin
        got = {bus.mem_addr, bus.mem_data};
        id  = bus.mem_addr[ADDR_W-1];
        total++;
        if ((id ? q1.size() : q0.size()) == 0) begin
          bad++;
          $display("[TB] FAIL unexpected_word: got %h, no word pending for req%0d", got, id);
        end else begin
          exp = id ? q1.pop_front() : q0.pop_front();
          if (got !== exp) begin
            bad++;
            $display("[TB] FAIL word_order req%0d: got %h, expected %h", id, got, exp);
          end
        end
        total++;
        if (bus.frame_done !== ((issued % WPF) == WPF - 1)) begin
          bad++;
          $display("[TB] FAIL frame_done word %0d: got %b, expected %b",
                   issued, bus.frame_done, ((issued % WPF) == WPF - 1));
        end
        issued++;
        id_log.push_back(id);
      end else begin
        total++;
        if (bus.frame_done !== 1'b0) begin
          bad++;
          $display("[TB] FAIL frame_done_idle: got %b, expected 0", bus.frame_done);
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.req0_we   = 1'b0;
    bus.req0_addr = '0;
    bus.req0_data = '0;
    bus.req1_we   = 1'b0;
    bus.req1_addr = '0;
    bus.req1_data = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle_inputs();
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q0.delete();
    q1.delete();
    id_log.delete();
    issued = 0;
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic drive_req0(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit keep);
    bus.req0_we   = 1'b1;
    bus.req0_addr = a;
    bus.req0_data = d;
    if (keep) q0.push_back({a, d});
  endtask

  task automatic drive_req1(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit keep);
    bus.req1_we   = 1'b1;
    bus.req1_addr = a;
    bus.req1_data = d;
    if (keep) q1.push_back({a, d});
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || bus.busy !== 1'b0) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (n >= 100) begin
      bad++;
      $display("[TB] FAIL %s drain_timeout: pending %0d/%0d busy=%b", name, q0.size(), q1.size(), bus.busy);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({bus.mem_we, bus.frame_done, bus.ovf0, bus.ovf1, bus.busy} !== 5'b0) begin
      bad++;
      $display("[TB] FAIL reset_state: we/fd/ovf0/ovf1/busy=%b, expected 00000",
               {bus.mem_we, bus.frame_done, bus.ovf0, bus.ovf1, bus.busy});
    end
    total++;
    if ({bus.mem_addr, bus.mem_data} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_port: got %h, expected 0", {bus.mem_addr, bus.mem_data});
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.mem_ready = 1'b1;
    drive_req0(20'h00010, 64'hA5, 1'b1);
    @(posedge clk);
    #1;
    idle_inputs();
    total++;
    if (bus.mem_we !== 1'b0 || bus.busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL single_push_cycle: we=%b busy=%b, expected we=0 busy=1", bus.mem_we, bus.busy);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 20'h00010 || bus.mem_data !== 64'hA5) begin
      bad++;
      $display("[TB] FAIL single_issue: we=%b addr=%h data=%h, expected 1 00010 a5",
               bus.mem_we, bus.mem_addr, bus.mem_data);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.mem_we !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL single_after: we=%b busy=%b, expected 0 0", bus.mem_we, bus.busy);
    end
  endtask

  // Both streams every cycle: drain is 1/cycle shared, so each FIFO grows by
  // one every other cycle and req1's 8th word (index 7) is the first drop.
  task automatic test_round_robin();
    int alt_err;
    do_reset();
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_req0(ADDR_W'(i), {$urandom, $urandom}, 1'b1);
      drive_req1(20'h80000 | ADDR_W'(i), {$urandom, $urandom}, i != 7);
      @(posedge clk);
      #1;
      if (i == 6) begin
        total++;
        if (bus.ovf1 !== 1'b0) begin
          bad++;
          $display("[TB] FAIL rr_ovf1_early: got %b at word 6, expected 0", bus.ovf1);
        end
      end
    end
    idle_inputs();
    total++;
    if (bus.ovf0 !== 1'b0 || bus.ovf1 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rr_ovf: ovf0=%b ovf1=%b, expected 0 1", bus.ovf0, bus.ovf1);
    end
    wait_drain("rr");
    alt_err = 0;
    foreach (id_log[k]) if (id_log[k] != bit'(k % 2)) alt_err++;
    total++;
    if (id_log.size() != 15 || alt_err != 0) begin
      bad++;
      $display("[TB] FAIL rr_alternation: %0d words, %0d out of turn, expected 15 and 0",
               id_log.size(), alt_err);
    end
  endtask

  task automatic test_overflow();
    int  n;
    bit  last_busy;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_req0(ADDR_W'(16 + i), {$urandom, $urandom}, i < DEPTH);
      @(posedge clk);
      #1;
      if (i == 3) begin
        total++;
        if (bus.ovf0 !== 1'b0) begin
          bad++;
          $display("[TB] FAIL ovf_early: got %b after 4 writes, expected 0", bus.ovf0);
        end
      end
    end
    idle_inputs();
    total++;
    if (bus.ovf0 !== 1'b1 || bus.mem_we !== 1'b0 || bus.busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ovf_set: ovf0=%b we=%b busy=%b, expected 1 0 1", bus.ovf0, bus.mem_we, bus.busy);
    end
    bus.mem_ready = 1'b1;
    n = 0;
    last_busy = 1'b0;
    for (int c = 0; c < 12 && bus.busy !== 1'b0; c++) begin
      @(posedge clk);
      #1;
      if (bus.mem_we === 1'b1) begin
        n++;
        last_busy = bus.busy;
      end
    end
    total++;
    if (n != 4 || last_busy !== 1'b1 || bus.busy !== 1'b0 || bus.ovf0 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ovf_drain: words=%0d busy_on_last=%b busy=%b ovf0=%b, expected 4 1 0 1",
               n, last_busy, bus.busy, bus.ovf0);
    end
  endtask

  task automatic test_full_push_pop();
    int n;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive_req0(ADDR_W'(32 + i), {$urandom, $urandom}, 1'b1);
      @(posedge clk);
      #1;
    end
    bus.mem_ready = 1'b1;
    drive_req0(ADDR_W'(40), {$urandom, $urandom}, 1'b1);
    @(posedge clk);
    #1;
    idle_inputs();
    total++;
    if (bus.ovf0 !== 1'b0 || bus.mem_we !== 1'b1) begin
      bad++;
      $display("[TB] FAIL full_push_pop: ovf0=%b we=%b, expected 0 1", bus.ovf0, bus.mem_we);
    end
    n = 1;
    for (int c = 0; c < 12 && bus.busy !== 1'b0; c++) begin
      @(posedge clk);
      #1;
      if (bus.mem_we === 1'b1) n++;
    end
    total++;
    if (n != DEPTH + 1 || bus.busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL full_push_pop_count: words=%0d busy=%b, expected %0d 0", n, bus.busy, DEPTH + 1);
    end
  endtask

  task automatic test_frame();
    int words;
    int pulses;
    int pulse_word;
    do_reset();
    bus.mem_ready = 1'b1;
    words = 0;
    pulses = 0;
    pulse_word = -1;
    for (int i = 0; i < 14; i++) begin
      if (i < 9) drive_req0(ADDR_W'(64 + i), {$urandom, $urandom}, 1'b1);
      else idle_inputs();
      @(posedge clk);
      #1;
      if (bus.mem_we === 1'b1) begin
        if (bus.frame_done === 1'b1) begin
          pulses++;
          pulse_word = words;
        end
        words++;
      end
    end
    idle_inputs();
    total++;
    if (words != 9 || pulses != 1 || pulse_word != WPF - 1) begin
      bad++;
      $display("[TB] FAIL frame_pulse: words=%0d pulses=%0d at word %0d, expected 9 1 7",
               words, pulses, pulse_word);
    end
  endtask

  task automatic test_reset_flush();
    int leaks;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_req0(ADDR_W'(96 + i), {$urandom, $urandom}, i < DEPTH);
      @(posedge clk);
      #1;
    end
    idle_inputs();
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (bus.mem_we !== 1'b1 || bus.ovf0 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL flush_setup: we=%b ovf0=%b, expected 1 1", bus.mem_we, bus.ovf0);
    end
    reset = 1'b1;
    drive_req0(ADDR_W'(200), 64'hDEAD, 1'b0);
    @(posedge clk);
    #1;
    q0.delete();
    q1.delete();
    issued = 0;
    total++;
    if (bus.mem_we !== 1'b0 || bus.busy !== 1'b0 || bus.ovf0 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL flush_reset: we=%b busy=%b ovf0=%b, expected 0 0 0", bus.mem_we, bus.busy, bus.ovf0);
    end
    idle_inputs();
    reset = 1'b0;
    leaks = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (bus.mem_we !== 1'b0) leaks++;
    end
    total++;
    if (leaks != 0) begin
      bad++;
      $display("[TB] FAIL flush_leak: %0d words issued after reset, expected 0", leaks);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    bus.mem_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_full_push_pop();
    test_frame();
    test_reset_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
